// File: rtl/icache_nway.sv
`default_nettype none
// ============================================================================
// Module   : icache_nway
// Purpose  : Parametrised N-way set-associative instruction cache for the
//            fetch stage. Round-robin replacement per set with invalid-way
//            priority, uncached bypass, sequenced invalidate-all and refills
//            over a single-ID AXI read channel (one burst outstanding).
// Ports    : clk, rstn (async active-low)
//            req_valid/req_addr/req_uncache/req_ready : fetch request
//            is_flush   : cancel the response of an accepted request
//            inv_all/inv_busy : invalidate-all start pulse / sweep busy
//            resp_valid/resp_data/resp_cnt : fetch group response
//            i_ar*/i_r* : AXI read address / data channel
// Options  : ICACHE_PERF_EN - adds perf_hit/perf_miss/perf_uncache counters
// Revision : 1.0 - initial parametrised release
// ============================================================================
module icache_nway #(
    parameter int WAYS        = 2,
    parameter int SETS        = 256,
    parameter int LINE_WORDS  = 4,
    parameter int FETCH_WORDS = 2
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               req_valid,
    input  logic [31:0]                        req_addr,
    input  logic                               req_uncache,
    output logic                               req_ready,
    input  logic                               is_flush,
    input  logic                               inv_all,
    output logic                               inv_busy,
    output logic                               resp_valid,
    output logic [32*FETCH_WORDS-1:0]          resp_data,
    output logic [$clog2(FETCH_WORDS):0]       resp_cnt,
    output logic                               i_arvalid,
    output logic [31:0]                        i_araddr,
    output logic [7:0]                         i_arlen,
    input  logic                               i_arready,
    input  logic                               i_rvalid,
    input  logic [31:0]                        i_rdata,
    input  logic                               i_rlast,
    output logic                               i_rready
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]                        perf_hit,
    output logic [31:0]                        perf_miss,
    output logic [31:0]                        perf_uncache
`endif
);

    localparam int c_OFF_W = $clog2(LINE_WORDS);
    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = 30 - c_OFF_W - c_IDX_W;
    localparam int c_WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int c_CNT_W = $clog2(FETCH_WORDS) + 1;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOOKUP  = 3'd1;
    localparam logic [2:0] c_MISS_AR = 3'd2;
    localparam logic [2:0] c_REFILL  = 3'd3;
    localparam logic [2:0] c_RESP    = 3'd4;
    localparam logic [2:0] c_INV     = 3'd5;

    logic [2:0]                      r_state;
    logic                            r_alive;
    logic [31:0]                     r_addr;
    logic                            r_uncache;
    logic                            r_flushed;
    logic                            r_inv_pend;
    logic [c_IDX_W-1:0]              r_set_cnt;
    logic [c_OFF_W-1:0]              r_beat;
    logic [31:0]                     r_buf [LINE_WORDS];
    logic [WAYS-1:0][SETS-1:0]       r_valid;
    logic [SETS-1:0][c_WAY_W-1:0]    r_rr;
    logic                            r_resp_valid;
    logic [32*FETCH_WORDS-1:0]       r_resp_data;
    logic [c_CNT_W-1:0]              r_resp_cnt;
    logic                            r_arvalid;
    logic [31:0]                     r_araddr;
    logic [7:0]                      r_arlen;
    logic                            r_rready;

    logic [c_TAG_W-1:0]              r_tag_mem  [WAYS][SETS];
    logic [32*LINE_WORDS-1:0]        r_data_mem [WAYS][SETS];
    logic [c_TAG_W-1:0]              r_rd_tag   [WAYS];
    logic [32*LINE_WORDS-1:0]        r_rd_line  [WAYS];

    logic [c_OFF_W-1:0]              w_off;
    logic [c_IDX_W-1:0]              w_idx;
    logic [c_TAG_W-1:0]              w_tag;
    logic [c_IDX_W-1:0]              w_req_idx;
    logic [c_CNT_W-1:0]              w_cnt;
    logic                            w_hit;
    logic [32*LINE_WORDS-1:0]        w_hit_line;
    logic [c_WAY_W-1:0]              w_victim;
    logic                            w_found;
    logic [32*LINE_WORDS-1:0]        w_fill_line;
    logic                            w_accept;
    logic                            w_fill_we;
    logic                            w_last_beat;

    assign w_off     = r_addr[c_OFF_W+1:2];
    assign w_idx     = r_addr[c_OFF_W+c_IDX_W+1:c_OFF_W+2];
    assign w_tag     = r_addr[31:c_OFF_W+c_IDX_W+2];
    assign w_req_idx = req_addr[c_OFF_W+c_IDX_W+1:c_OFF_W+2];

    // A pending or same-cycle invalidate takes priority over new requests.
    assign req_ready   = r_alive && (r_state == c_IDLE) && !inv_all && !r_inv_pend;
    assign w_accept    = req_valid && req_ready;
    assign w_last_beat = (r_state == c_REFILL) && i_rvalid && i_rlast;
    assign w_fill_we   = w_last_beat && !r_uncache;

    assign inv_busy    = (r_state == c_INV);
    // A flush arriving while the response is on the bus still cancels it.
    assign resp_valid  = r_resp_valid && !is_flush;
    assign resp_data   = r_resp_data;
    assign resp_cnt    = r_resp_cnt;
    assign i_arvalid   = r_arvalid;
    assign i_araddr    = r_araddr;
    assign i_arlen     = r_arlen;
    assign i_rready    = r_rready;

    // Words available from the offset to the end of the line, capped.
    always_comb begin
        if (LINE_WORDS - int'(w_off) > FETCH_WORDS)
            w_cnt = c_CNT_W'(FETCH_WORDS);
        else
            w_cnt = c_CNT_W'(LINE_WORDS - int'(w_off));
    end

    always_comb begin
        w_hit      = 1'b0;
        w_hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && (r_rd_tag[w] == w_tag)) begin
                w_hit      = 1'b1;
                w_hit_line = r_rd_line[w];
            end
        end
    end

    // Lowest-numbered invalid way wins; otherwise the set's round-robin way.
    always_comb begin
        w_victim = r_rr[w_idx];
        w_found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && !r_valid[w][w_idx]) begin
                w_found  = 1'b1;
                w_victim = c_WAY_W'(w);
            end
        end
    end

    // Line buffer with the beat currently on the bus merged in.
    always_comb begin
        for (int k = 0; k < LINE_WORDS; k++)
            w_fill_line[32*k +: 32] = (c_OFF_W'(k) == r_beat) ? i_rdata : r_buf[k];
    end

    function automatic logic [32*FETCH_WORDS-1:0] f_pick(
        input logic [32*LINE_WORDS-1:0] line,
        input logic [c_OFF_W-1:0]       base
    );
        logic [32*FETCH_WORDS-1:0] v;
        v = '0;
        for (int k = 0; k < FETCH_WORDS; k++)
            if (int'(base) + k < LINE_WORDS)
                v[32*k +: 32] = line[32*(int'(base)+k) +: 32];
        return v;
    endfunction

    // Tag/data arrays: synchronous read on accept, write on the last refill beat.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int w = 0; w < WAYS; w++) begin
                r_rd_tag[w]  <= r_tag_mem[w][w_req_idx];
                r_rd_line[w] <= r_data_mem[w][w_req_idx];
            end
        end
        if (w_fill_we) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w_victim == c_WAY_W'(w)) begin
                    r_tag_mem[w][w_idx]  <= w_tag;
                    r_data_mem[w][w_idx] <= w_fill_line;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= c_IDLE;
            r_alive      <= 1'b0;
            r_addr       <= '0;
            r_uncache    <= 1'b0;
            r_flushed    <= 1'b0;
            r_inv_pend   <= 1'b0;
            r_set_cnt    <= '0;
            r_beat       <= '0;
            for (int k = 0; k < LINE_WORDS; k++) r_buf[k] <= '0;
            r_valid      <= '0;
            r_rr         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_cnt   <= '0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_rready     <= 1'b0;
        end else begin
            r_alive      <= 1'b1;
            r_resp_valid <= 1'b0;
            if (inv_all && (r_state != c_IDLE) && (r_state != c_INV))
                r_inv_pend <= 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (r_alive && (inv_all || r_inv_pend)) begin
                        r_state    <= c_INV;
                        r_set_cnt  <= '0;
                        r_inv_pend <= 1'b0;
                    end else if (w_accept) begin
                        r_addr    <= req_addr;
                        r_uncache <= req_uncache;
                        r_state   <= c_LOOKUP;
                    end
                end
                c_LOOKUP: begin
                    if (is_flush) begin
                        r_state <= c_IDLE;
                    end else if (w_hit && !r_uncache) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= f_pick(w_hit_line, w_off);
                        r_resp_cnt   <= w_cnt;
                        r_state      <= c_RESP;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_uncache ? r_addr
                                               : {r_addr[31:c_OFF_W+2], {(c_OFF_W+2){1'b0}}};
                        r_arlen   <= r_uncache ? 8'(w_cnt - 1'b1) : 8'(LINE_WORDS - 1);
                        r_flushed <= 1'b0;
                        r_state   <= c_MISS_AR;
                    end
                end
                c_MISS_AR: begin
                    if (is_flush) r_flushed <= 1'b1;
                    if (i_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= c_REFILL;
                    end
                end
                c_REFILL: begin
                    if (is_flush) r_flushed <= 1'b1;
                    if (i_rvalid) begin
                        r_buf[r_beat] <= i_rdata;
                        r_beat        <= r_beat + 1'b1;
                    end
                    if (w_last_beat) begin
                        r_rready <= 1'b0;
                        if (!r_uncache) begin
                            for (int w = 0; w < WAYS; w++)
                                if (w_victim == c_WAY_W'(w)) r_valid[w][w_idx] <= 1'b1;
                            r_rr[w_idx] <= (r_rr[w_idx] == c_WAY_W'(WAYS - 1)) ? '0
                                                                              : r_rr[w_idx] + 1'b1;
                        end
                        // A flushed burst still completes but returns nothing.
                        r_resp_valid <= !(r_flushed || is_flush);
                        r_resp_data  <= f_pick(w_fill_line, r_uncache ? {c_OFF_W{1'b0}} : w_off);
                        r_resp_cnt   <= w_cnt;
                        r_state      <= c_RESP;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                c_INV: begin
                    for (int w = 0; w < WAYS; w++) r_valid[w][r_set_cnt] <= 1'b0;
                    r_set_cnt <= r_set_cnt + 1'b1;
                    if (r_set_cnt == c_IDX_W'(SETS - 1)) r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_perf_hit;
    logic [31:0] r_perf_miss;
    logic [31:0] r_perf_unc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
            r_perf_unc  <= '0;
        end else if (inv_all && (r_state != c_INV)) begin
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
            r_perf_unc  <= '0;
        end else if (r_state == c_LOOKUP) begin
            if (r_uncache) begin
                if (r_perf_unc != '1) r_perf_unc <= r_perf_unc + 1'b1;
            end else if (w_hit) begin
                if (r_perf_hit != '1) r_perf_hit <= r_perf_hit + 1'b1;
            end else begin
                if (r_perf_miss != '1) r_perf_miss <= r_perf_miss + 1'b1;
            end
        end
    end

    assign perf_hit     = r_perf_hit;
    assign perf_miss    = r_perf_miss;
    assign perf_uncache = r_perf_unc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_nway
// Purpose  : Self-checking bench for icache_nway. A behavioural cache model
//            (per-set tag lists, round-robin pointers) predicts hit/miss, AR
//            fields and returned words; an AXI slave model serves bursts from
//            a hashed memory image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_nway;
    localparam int WAYS        = 2;
    localparam int SETS        = 16;
    localparam int LINE_WORDS  = 4;
    localparam int FETCH_WORDS = 2;
    localparam int CW          = $clog2(FETCH_WORDS) + 1;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic                     req_valid = 1'b0;
    logic [31:0]              req_addr = '0;
    logic                     req_uncache = 1'b0;
    logic                     req_ready;
    logic                     is_flush = 1'b0;
    logic                     inv_all = 1'b0;
    logic                     inv_busy;
    logic                     resp_valid;
    logic [32*FETCH_WORDS-1:0] resp_data;
    logic [CW-1:0]            resp_cnt;
    logic                     i_arvalid;
    logic [31:0]              i_araddr;
    logic [7:0]               i_arlen;
    logic                     i_arready;
    logic                     i_rvalid;
    logic [31:0]              i_rdata;
    logic                     i_rlast;
    logic                     i_rready;
`ifdef ICACHE_PERF_EN
    logic [31:0]              perf_hit, perf_miss, perf_uncache;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [39:0] ar_log [$];

    // Reference model state.
    int unsigned m_tag [WAYS][SETS];
    bit          m_val [WAYS][SETS];
    int          m_rr  [SETS];

    always #5 clk = ~clk;

    icache_nway #(
        .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS), .FETCH_WORDS(FETCH_WORDS)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_addr(req_addr), .req_uncache(req_uncache),
        .req_ready(req_ready), .is_flush(is_flush), .inv_all(inv_all),
        .inv_busy(inv_busy), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_cnt(resp_cnt), .i_arvalid(i_arvalid), .i_araddr(i_araddr),
        .i_arlen(i_arlen), .i_arready(i_arready), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rready(i_rready)
`ifdef ICACHE_PERF_EN
        , .perf_hit(perf_hit), .perf_miss(perf_miss), .perf_uncache(perf_uncache)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int m_off(input logic [31:0] a);
        return int'((a >> 2) % LINE_WORDS);
    endfunction
    function automatic int m_idx(input logic [31:0] a);
        return int'(((a >> 2) / LINE_WORDS) % SETS);
    endfunction
    function automatic int unsigned m_tg(input logic [31:0] a);
        return (a >> 2) / (LINE_WORDS * SETS);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        for (int w = 0; w < WAYS; w++)
            if (m_val[w][m_idx(a)] && m_tag[w][m_idx(a)] == m_tg(a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        int s, v;
        s = m_idx(a);
        v = m_rr[s];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!m_val[w][s]) v = w;
        m_val[v][s] = 1'b1;
        m_tag[v][s] = m_tg(a);
        m_rr[s]     = (m_rr[s] + 1) % WAYS;
    endfunction

    // AXI read slave: accepts AR after a random delay, returns memory beats.
    initial begin : axi_slave
        logic [31:0] a;
        logic [7:0]  l;
        int          wt;
        i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (i_arvalid) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                a = i_araddr;
                l = i_arlen;
                ar_log.push_back({a, l});
                i_arready = 1'b1;
                @(negedge clk);
                i_arready = 1'b0;
                for (int b = 0; b <= int'(l); b++) begin
                    wt = 0;
                    while (!i_rready && wt < 50) begin @(negedge clk); wt++; end
                    if ($urandom_range(0, 3) == 0) begin
                        i_rvalid = 1'b0;
                        @(negedge clk);
                    end
                    i_rvalid = 1'b1;
                    i_rdata  = mem_word(a + 32'(4 * b));
                    i_rlast  = (b == int'(l));
                    @(negedge clk);
                end
                i_rvalid = 1'b0;
                i_rlast  = 1'b0;
            end
        end
    end

    // mode 0: normal, 1: flush pulse during refill, 2: flush pulse in lookup
    task automatic do_fetch(input logic [31:0] a, input bit unc, input int mode);
        int ar0, n, cnt;
        bit hit, seen, fl_done, exp_ar;
        logic [63:0] exp_d, mask;
        logic [39:0] ent;
        hit = !unc && model_hit(a);
        cnt = LINE_WORDS - m_off(a);
        if (cnt > FETCH_WORDS) cnt = FETCH_WORDS;
        ar0 = ar_log.size();
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_uncache = unc;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            check("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0; fl_done = 1'b0; n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (resp_valid) seen = 1'b1;
            if (is_flush) is_flush = 1'b0;
            else if (!fl_done && ((mode == 1 && i_rready) || (mode == 2 && n == 1))) begin
                is_flush = 1'b1;
                fl_done  = 1'b1;
            end
            if (mode == 0 && seen) break;
            if (mode != 0 && n > 1 && req_ready && !is_flush) break;
            if (n >= 150) break;
        end
        is_flush = 1'b0;
        if (mode == 0) begin
            check("resp_seen", 64'(seen), 64'd1);
            if (seen) begin
                exp_d = '0; mask = '0;
                for (int k = 0; k < FETCH_WORDS; k++)
                    if (k < cnt) begin
                        exp_d[32*k +: 32] = mem_word(a + 32'(4 * k));
                        mask[32*k +: 32]  = '1;
                    end
                check("resp_cnt", 64'(resp_cnt), 64'(cnt));
                check("resp_data", 64'(resp_data) & mask, exp_d);
                if (hit) check("hit_latency", 64'(n), 64'd2);
            end
        end else begin
            check("flush_no_resp", 64'(seen), 64'd0);
            check("flush_back_idle", 64'(n < 150), 64'd1);
        end
        exp_ar = (mode != 2) && !hit;
        check("ar_issued", 64'(ar_log.size() - ar0), 64'(exp_ar));
        if (exp_ar && ar_log.size() > ar0) begin
            ent = ar_log[ar_log.size() - 1];
            check("araddr", 64'(ent[39:8]), unc ? 64'(a) : 64'(a & ~32'(LINE_WORDS * 4 - 1)));
            check("arlen", 64'(ent[7:0]), unc ? 64'(cnt - 1) : 64'(LINE_WORDS - 1));
        end
        if (mode != 2 && !unc && !hit) model_fill(a);
    endtask

    task automatic do_inv();
        int n;
        @(negedge clk);
        inv_all = 1'b1;
        #1 check("inv_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        inv_all = 1'b0;
        n = 0;
        while (inv_busy && n < SETS + 20) begin
            if (req_ready) check("inv_req_ready_busy", 64'(req_ready), 64'd0);
            n++;
            @(negedge clk);
        end
        check("inv_cycles", 64'(n), 64'(SETS));
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) m_val[w][s] = 1'b0;
`ifdef ICACHE_PERF_EN
        check("perf_cleared", {perf_hit, perf_miss | perf_uncache}, 64'd0);
`endif
    endtask

    initial begin : main
        logic [31:0] a;
        bit          unc;
        int          mode;
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin m_val[w][s] = 1'b0; m_tag[w][s] = 0; end
        end
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_resp_cnt", 64'(resp_cnt), 64'd0);
        check("rst_ar_r", {62'd0, i_arvalid, i_rready}, 64'd0);
        check("rst_inv_busy", 64'(inv_busy), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Cold miss, then hits within the line including the last word.
        do_fetch(32'h1000_0000, 1'b0, 0);
        do_fetch(32'h1000_0008, 1'b0, 0);
        do_fetch(32'h1000_000C, 1'b0, 0);
        // Uncached: always goes to the bus, never allocates.
        do_fetch(32'h1C00_0004, 1'b1, 0);
        do_fetch(32'h1C00_0004, 1'b1, 0);
        // Three lines in set 5 of a 2-way cache.
        do_fetch(32'h2000_0050, 1'b0, 0);
        do_fetch(32'h2000_0150, 1'b0, 0);
        do_fetch(32'h2000_0250, 1'b0, 0);
        do_fetch(32'h2000_0154, 1'b0, 0);
        do_fetch(32'h2000_0050, 1'b0, 0);
        // Flush during refill still allocates the line.
        do_fetch(32'h3000_0000, 1'b0, 1);
        do_fetch(32'h3000_0004, 1'b0, 0);
        // Flush in lookup drops the request entirely.
        do_fetch(32'h3000_0040, 1'b0, 2);
        do_fetch(32'h3000_0040, 1'b0, 0);
        // Invalidate-all, then previously cached lines miss.
        do_inv();
        do_fetch(32'h1000_0000, 1'b0, 0);
        do_fetch(32'h3000_0004, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            a = 32'h4000_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4)
                | ($urandom_range(0, LINE_WORDS - 1) << 2);
            unc  = ($urandom_range(0, 5) == 0);
            mode = 0;
            if ((unc || !model_hit(a)) && $urandom_range(0, 7) == 0) mode = 1;
            else if ($urandom_range(0, 9) == 0) mode = 2;
            do_fetch(a, unc, mode);
            if (i == 100) do_inv();
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
